// File: rtl/rom_loader_if.sv
// Byte-source handshake, memory write port and status signals of the ROM loader.
// The slave modport is the loader's view; master is the byte source / CPU side.
interface rom_loader_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 12
);
  logic          start_i;
  logic [AW:0]   len_i;
  logic          byte_valid_i;
  logic [7:0]    byte_data_i;
  logic          byte_ready_o;
  logic          wen_o;
  logic [AW-1:0] w_addr_o;
  logic [DW-1:0] w_data_o;
  logic          cpu_hold_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [7:0]    csum_o;

  modport slave (
    input  start_i, len_i, byte_valid_i, byte_data_i,
    output byte_ready_o, wen_o, w_addr_o, w_data_o,
           cpu_hold_o, busy_o, done_o, err_o, csum_o
  );

  modport master (
    output start_i, len_i, byte_valid_i, byte_data_i,
    input  byte_ready_o, wen_o, w_addr_o, w_data_o,
           cpu_hold_o, busy_o, done_o, err_o, csum_o
  );
endinterface

// File: rtl/rom_loader.sv
// Packs a little-endian byte stream into DW-bit words and writes them to consecutive
// memory addresses from 0, holding the CPU stalled while the load is in progress.
module rom_loader #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 12,
  parameter int unsigned MEM_NUM = 4096,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  rom_loader_if.slave bus
);

  localparam int unsigned BPW = DW / 8;
  localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_word;
  logic [DW-1:0]   w_word_nxt;
  logic [BCW-1:0]  r_byte_cnt;
  logic [TW-1:0]   r_tcnt;
  logic [AW-1:0]   r_addr;
  logic [LW-1:0]   r_words_left;
  logic            w_hs;
  logic            w_accept;
  logic            w_zero_len;
  logic            w_len_bad;
  logic            w_abort;
  logic            w_last_byte;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state plus the single-cycle events that steer the datapath
  always_comb begin
    w_state_nxt = r_state;
    w_hs        = 1'b0;
    w_accept    = 1'b0;
    w_zero_len  = 1'b0;
    w_len_bad   = 1'b0;
    w_abort     = 1'b0;
    w_last_byte = (r_byte_cnt == BCW'(BPW - 1));
    w_word_nxt  = r_word;
    for (int k = 0; k < int'(BPW); k++) begin
      if (r_byte_cnt == BCW'(k)) w_word_nxt[8*k +: 8] = bus.byte_data_i;
    end
    case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          if (bus.len_i == '0) begin
            w_zero_len  = 1'b1;
            w_state_nxt = S_DONE;
          end else if (bus.len_i > LW'(MEM_NUM)) begin
            w_len_bad = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_RECV;
          end
        end
      end
      S_RECV: begin
        w_hs = bus.byte_valid_i & bus.byte_ready_o;
        if (w_hs) begin
          if (w_last_byte) w_state_nxt = S_WRITE;
        end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WRITE: w_state_nxt = (r_words_left == LW'(1)) ? S_DONE : S_RECV;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_word           <= '0;
      r_byte_cnt       <= '0;
      r_tcnt           <= '0;
      r_addr           <= '0;
      r_words_left     <= '0;
      bus.byte_ready_o <= 1'b0;
      bus.wen_o        <= 1'b0;
      bus.w_addr_o     <= '0;
      bus.w_data_o     <= '0;
      bus.cpu_hold_o   <= 1'b0;
      bus.busy_o       <= 1'b0;
      bus.done_o       <= 1'b0;
      bus.err_o        <= 1'b0;
      bus.csum_o       <= '0;
    end else begin
      bus.byte_ready_o <= (w_state_nxt == S_RECV);
      bus.busy_o       <= (w_state_nxt != S_IDLE);
      bus.wen_o        <= (w_state_nxt == S_WRITE);
      bus.done_o       <= (w_state_nxt == S_DONE);
      if (w_zero_len) begin
        bus.err_o  <= 1'b0;
        bus.csum_o <= '0;
      end
      if (w_len_bad) bus.err_o <= 1'b1;
      if (w_accept) begin
        r_words_left   <= bus.len_i;
        r_addr         <= '0;
        r_byte_cnt     <= '0;
        r_tcnt         <= '0;
        bus.csum_o     <= '0;
        bus.err_o      <= 1'b0;
        bus.cpu_hold_o <= 1'b1;
      end
      if (w_hs) begin
        r_word     <= w_word_nxt;
        bus.csum_o <= bus.csum_o + bus.byte_data_i;
        r_tcnt     <= '0;
        r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + BCW'(1);
        if (w_last_byte) begin
          bus.w_addr_o <= r_addr;
          bus.w_data_o <= w_word_nxt;
        end
      end else if (r_state == S_RECV) begin
        r_tcnt <= r_tcnt + TW'(1);
      end
      if (w_abort) begin
        bus.err_o      <= 1'b1;
        bus.cpu_hold_o <= 1'b0;
      end
      if (r_state == S_WRITE) begin
        r_addr       <= r_addr + AW'(1);
        r_words_left <= r_words_left - LW'(1);
        r_tcnt       <= '0;
      end
      if (r_state == S_DONE) bus.cpu_hold_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: table-driven loads plus hand-written corner cases,
// with memory writes checked against a queue of expected {addr, data} pairs.
module tb_rom_loader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;
  localparam int unsigned MEM_NUM = 4096;
  localparam int unsigned TIMEOUT = 8;

  typedef struct packed {
    logic [12:0] len;
    logic [1:0]  gap;
    logic [63:0] bytes;
    logic [63:0] words;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   nchk = 0;
  int   nerr = 0;
  int   done_cnt = 0;
  int   wen_cnt = 0;
  logic [43:0] exp_q[$];
  vec_t vecs[4];

  rom_loader_if #(.DW(DW), .AW(AW)) bus ();

  rom_loader #(.DW(DW), .AW(AW), .MEM_NUM(MEM_NUM), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every bench cycle passes through here so no write pulse or done pulse is missed
  task automatic tick();
    logic [43:0] e;
    @(negedge clk);
    if (bus.wen_o === 1'b1) begin
      wen_cnt++;
      if (exp_q.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL wen_unexpected: got write addr %0h data %0h, expected no write",
                 bus.w_addr_o, bus.w_data_o);
      end else begin
        e = exp_q.pop_front();
        chk("w_addr", 64'(bus.w_addr_o), 64'(e[43:32]));
        chk("w_data", 64'(bus.w_data_o), 64'(e[31:0]));
      end
    end
    if (bus.done_o === 1'b1) done_cnt++;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 64'(bus.byte_ready_o), 0);
    chk({tag, "_wen"},   64'(bus.wen_o), 0);
    chk({tag, "_addr"},  64'(bus.w_addr_o), 0);
    chk({tag, "_data"},  64'(bus.w_data_o), 0);
    chk({tag, "_hold"},  64'(bus.cpu_hold_o), 0);
    chk({tag, "_busy"},  64'(bus.busy_o), 0);
    chk({tag, "_done"},  64'(bus.done_o), 0);
    chk({tag, "_err"},   64'(bus.err_o), 0);
    chk({tag, "_csum"},  64'(bus.csum_o), 0);
  endtask

  task automatic start_load(input logic [12:0] len);
    bus.start_i = 1'b1;
    bus.len_i   = len;
    tick();
    bus.start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output int waited);
    waited = 0;
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = b;
    while (bus.byte_ready_o !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) begin
      nchk++;
      nerr++;
      $display("FAIL ready_timeout: waited %0d cycles, expected ready within 50", waited);
    end
    tick();
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 40) begin
      tick();
      n++;
    end
    chk("done_pulses", 64'(done_cnt - d0), 1);
  endtask

  task automatic run_load(input vec_t v, input string tag);
    int d0;
    int waited;
    logic [7:0] cs;
    logic [7:0] b;
    d0 = done_cnt;
    cs = 8'h00;
    start_load(v.len);
    chk({tag, "_hold_on"}, 64'(bus.cpu_hold_o), 1);
    chk({tag, "_busy_on"}, 64'(bus.busy_o), 1);
    for (int w = 0; w < int'(v.len); w++) begin
      exp_q.push_back({12'(w), v.words[32*w +: 32]});
      for (int k = 0; k < 4; k++) begin
        b  = v.bytes[8*(4*w+k) +: 8];
        cs = cs + b;
        send_byte(b, waited);
        if (v.gap != 2'd0) chk({tag, "_ready_stall"}, 64'(waited), 0);
        if (k == 3) chk({tag, "_wen_latency"}, 64'(bus.wen_o), 1);
        repeat (int'(v.gap)) tick();
      end
    end
    wait_done(d0);
    tick();
    chk({tag, "_csum"}, 64'(bus.csum_o), 64'(cs));
    chk({tag, "_err"}, 64'(bus.err_o), 0);
    chk({tag, "_hold_off"}, 64'(bus.cpu_hold_o), 0);
    chk({tag, "_busy_off"}, 64'(bus.busy_o), 0);
    chk({tag, "_pending"}, 64'(exp_q.size()), 0);
  endtask

  initial begin
    int waited;
    int w0;
    int d0;
    vecs[0] = '{len: 13'd2, gap: 2'd0, bytes: 64'h00000D93_00000D13, words: 64'h00000D93_00000D13};
    vecs[1] = '{len: 13'd1, gap: 2'd1, bytes: 64'h00000000_04030201, words: 64'h00000000_04030201};
    vecs[2] = '{len: 13'd2, gap: 2'd2, bytes: 64'h44332211_DDCCBBAA, words: 64'h44332211_DDCCBBAA};
    vecs[3] = '{len: 13'd1, gap: 2'd0, bytes: 64'h00000000_FFFFFFFF, words: 64'h00000000_FFFFFFFF};

    rst = 1'b0;
    bus.start_i = 1'b0;
    bus.len_i = '0;
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i = '0;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_load(vecs[i], $sformatf("vec%0d", i));
    chk("vec0_csum_const", 64'(vecs[0].len), 2);

    // Timeout: two bytes then silence aborts after TIMEOUT idle cycles
    w0 = wen_cnt;
    start_load(13'd1);
    send_byte(8'h10, waited);
    send_byte(8'h20, waited);
    repeat (TIMEOUT - 1) tick();
    chk("tmo_busy_before", 64'(bus.busy_o), 1);
    tick();
    chk("tmo_busy", 64'(bus.busy_o), 0);
    chk("tmo_err", 64'(bus.err_o), 1);
    chk("tmo_hold", 64'(bus.cpu_hold_o), 0);
    chk("tmo_csum", 64'(bus.csum_o), 64'h30);
    chk("tmo_no_wen", 64'(wen_cnt - w0), 0);
    d0 = done_cnt;
    start_load(13'd0);
    chk("tmo_err_cleared", 64'(bus.err_o), 0);
    chk("len0_done", 64'(done_cnt - d0), 1);
    tick();

    // Oversized length is rejected without entering RECV
    start_load(13'(MEM_NUM + 1));
    chk("big_err", 64'(bus.err_o), 1);
    chk("big_busy", 64'(bus.busy_o), 0);
    chk("big_hold", 64'(bus.cpu_hold_o), 0);
    bus.byte_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("big_no_ready", 64'(bus.byte_ready_o), 0);
    end
    bus.byte_valid_i = 1'b0;
    d0 = done_cnt;
    w0 = wen_cnt;
    start_load(13'd0);
    chk("zero_done", 64'(done_cnt - d0), 1);
    chk("zero_err", 64'(bus.err_o), 0);
    chk("zero_csum", 64'(bus.csum_o), 0);
    repeat (3) tick();
    chk("zero_no_wen", 64'(wen_cnt - w0), 0);
    run_load(vecs[1], "prereset");

    // Reset in the middle of a word discards it
    w0 = wen_cnt;
    start_load(13'd3);
    send_byte(8'h11, waited);
    send_byte(8'h22, waited);
    send_byte(8'h33, waited);
    rst = 1'b0;
    tick();
    check_zero("midrst");
    rst = 1'b1;
    tick();
    chk("midrst_no_wen", 64'(wen_cnt - w0), 0);
    run_load('{len: 13'd1, gap: 2'd0, bytes: 64'h00000000_A5C3E1F0, words: 64'h00000000_A5C3E1F0},
             "restart");

    // start_i during RECV must not restart the load
    d0 = done_cnt;
    start_load(13'd2);
    exp_q.push_back({12'd0, 32'h04030201});
    exp_q.push_back({12'd1, 32'h08070605});
    send_byte(8'h01, waited);
    send_byte(8'h02, waited);
    bus.start_i = 1'b1;
    bus.len_i = 13'd5;
    tick();
    bus.start_i = 1'b0;
    for (int k = 3; k <= 8; k++) send_byte(8'(k), waited);
    repeat (12) tick();
    chk("restart_ignored_done", 64'(done_cnt - d0), 1);
    chk("restart_ignored_busy", 64'(bus.busy_o), 0);
    chk("restart_ignored_pending", 64'(exp_q.size()), 0);
    chk("restart_ignored_csum", 64'(bus.csum_o), 64'h24);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
